// File: rtl/mvau_wmem_streamer_if.sv
// Weight stream interface between the MVAU weight streamer and a PE.
// master drives out_v/out_wgt/out_last, slave drives out_rdy.
interface mvau_wmem_streamer_if #(
  parameter int W = 2
);
  logic         out_v;
  logic         out_rdy;
  logic [W-1:0] out_wgt;
  logic         out_last;

  modport master (
    output out_v,
    output out_wgt,
    output out_last,
    input  out_rdy
  );

  modport slave (
    input  out_v,
    input  out_wgt,
    input  out_last,
    output out_rdy
  );
endinterface

// File: rtl/mvau_wmem_streamer.sv
// MVAU weight memory address sequencer with a 2-entry skid buffer.
// Ports: aclk/areset (sync, high), start/busy/done frame control,
//   wmem_addr/wmem_out to a 1-cycle-latency memory, out_if weight stream.
module mvau_wmem_streamer #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NUM_REPS     = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_out,
  mvau_wmem_streamer_if.master    out_if
);

  localparam int W  = SIMD * TW;
  localparam int PW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;
  localparam int AW = WMEM_ADDR_BW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(WMEM_DEPTH - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(NUM_REPS - 1);

  typedef struct packed {
    logic         last;
    logic [W-1:0] wgt;
  } ent_t;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;
  logic [1:0]    occ_q, occ_d;
  ent_t          head_q, head_d;
  ent_t          tail_q, tail_d;
  logic          done_q, done_d;

  logic       out_v;
  logic       pop;
  logic       issue;
  logic       wrap;
  logic       last_rd;
  logic       fin;
  logic [2:0] fill;
  ent_t       cap;

  assign out_v = (occ_q != 2'd0);
  assign pop   = out_v & out_if.out_rdy;

  always_comb begin
    fill    = {1'b0, occ_q} + {2'b0, infl_q};
    // Reserve a slot for every word already owed to the buffer.
    issue   = (state_q == S_RUN) && (fill <= 3'd1 + {2'b0, pop});
    wrap    = (addr_q == LAST_ADDR);
    last_rd = issue && wrap && (pass_q == LAST_PASS);
    // Final word leaves with nothing behind it and nothing in flight.
    fin     = (state_q == S_DRAIN) && pop
              && (occ_q == 2'd1) && !infl_q;
    cap     = '{last: infl_last_q, wgt: wmem_out};

    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;
    infl_d      = issue;
    infl_last_d = issue && wrap;
    done_d      = fin;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
          pass_d  = '0;
        end
      end
      (state_q == S_RUN): begin
        if (last_rd) state_d = S_DRAIN;
      end
      (state_q == S_DRAIN): begin
        if (fin) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      addr_d = wrap ? '0 : addr_q + AW'(1);
      if (wrap) pass_d = last_rd ? '0 : pass_q + PW'(1);
    end

    if (infl_q && pop) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
        tail_d = cap;
      end else begin
        head_d = cap;
      end
    end else if (pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end else if (infl_q) begin
      if (occ_q == 2'd0) head_d = cap;
      else               tail_d = cap;
      occ_d = occ_q + 2'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pass_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      done_q      <= done_d;
    end
  end

  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = done_q;
  assign wmem_addr       = addr_q;
  assign out_if.out_v    = out_v;
  assign out_if.out_wgt  = head_q.wgt;
  assign out_if.out_last = head_q.last;

  a_no_overflow: assert property (
    @(posedge aclk) disable iff (areset)
    (occ_q != 2'd3) && !((occ_q == 2'd2) && infl_q)
  );

endmodule

// File: tb/tb_mvau_wmem_streamer.sv
// Scoreboard bench for mvau_wmem_streamer: two configs (4x2 and 1x3).
// A negedge monitor pops expected words and checks busy/done/hold.
module tb_mvau_wmem_streamer;
  localparam int SIMD = 4;
  localparam int TW   = 2;
  localparam int W    = SIMD * TW;
  localparam int AW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset, start, out_rdy, sel;
  logic          start_a, start_b;
  logic          busy_a, done_a, busy_b, done_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  wout_a, wout_b;
  logic [W-1:0]  mem_a [16];
  logic [W-1:0]  mem_b [16];

  mvau_wmem_streamer_if #(.W(W)) if_a ();
  mvau_wmem_streamer_if #(.W(W)) if_b ();

  assign if_a.out_rdy = out_rdy;
  assign if_b.out_rdy = out_rdy;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  mvau_wmem_streamer #(
    .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(4),
    .WMEM_ADDR_BW(AW), .NUM_REPS(2)
  ) dut_a (
    .aclk(clk), .areset(areset), .start(start_a),
    .busy(busy_a), .done(done_a), .wmem_addr(addr_a),
    .wmem_out(wout_a), .out_if(if_a)
  );

  mvau_wmem_streamer #(
    .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(1),
    .WMEM_ADDR_BW(AW), .NUM_REPS(3)
  ) dut_b (
    .aclk(clk), .areset(areset), .start(start_b),
    .busy(busy_b), .done(done_b), .wmem_addr(addr_b),
    .wmem_out(wout_b), .out_if(if_b)
  );

  always @(posedge clk) wout_a <= mem_a[addr_a];
  always @(posedge clk) wout_b <= mem_b[addr_b];

  // View of the currently selected instance
  logic          m_v, m_last, m_busy, m_done;
  logic [W-1:0]  m_wgt;
  logic [AW-1:0] m_addr;
  int            m_depth, m_reps;
  assign m_v     = sel ? if_b.out_v    : if_a.out_v;
  assign m_last  = sel ? if_b.out_last : if_a.out_last;
  assign m_wgt   = sel ? if_b.out_wgt  : if_a.out_wgt;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_addr  = sel ? addr_b : addr_a;
  assign m_depth = sel ? 1 : 4;
  assign m_reps  = sel ? 3 : 2;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [W:0] q[$];
  bit         en = 0;
  bit         m_idle = 1;
  bit         exp_done = 0;
  bit         stall_prev = 0;
  logic [W:0] prev_ent;
  int         rem = 0;
  int         cyc = 0;
  int         f_first = 0;
  int         f_last = 0;
  int         started = 0;

  always @(negedge clk) begin
    logic       hs;
    logic [W:0] e;
    int         n;
    cyc++;
    n = m_depth * m_reps;
    if (en) begin
      if (m_done || exp_done) chk("done", 32'(m_done), 32'(exp_done));
      chk("busy", 32'(m_busy), 32'(!m_idle));
      if (stall_prev) begin
        chk("hold_v", 32'(m_v), 32'd1);
        chk("hold_wgt", 32'({m_last, m_wgt}), 32'(prev_ent));
      end
      hs = m_v && out_rdy && !areset;
      if (hs) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got %0h expected none",
                   {m_last, m_wgt});
        end else begin
          e = q.pop_front();
          chk("word", 32'({m_last, m_wgt}), 32'(e));
        end
      end
      exp_done = 0;
      if (areset) begin
        q.delete();
        m_idle = 1;
        rem = 0;
      end else if (m_idle) begin
        if (start) begin
          for (int i = 0; i < n; i++) begin
            int a;
            a = i % m_depth;
            q.push_back({a == m_depth - 1,
                         sel ? mem_b[a] : mem_a[a]});
          end
          m_idle = 0;
          rem = n;
          started++;
        end
      end else if (hs) begin
        if (rem == n) f_first = cyc;
        rem--;
        if (rem == 0) begin
          f_last = cyc;
          m_idle = 1;
          exp_done = 1;
        end
      end
      stall_prev = m_v && !out_rdy && !areset;
      prev_ent = {m_last, m_wgt};
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_frame(input bit rnd);
    int k;
    k = 0;
    while (!(m_idle && q.size() == 0) && k < 400) begin
      @(posedge clk); #1;
      if (rnd) out_rdy = 1'($urandom_range(0, 1));
      k++;
    end
    chk("frame_end", 32'(m_idle && q.size() == 0), 32'd1);
    out_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    areset = 1; start = 0; out_rdy = 1; sel = 0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = W'($urandom);
      mem_b[i] = W'($urandom);
    end
    mem_b[0] = 8'd5;
    repeat (3) @(posedge clk);
    #1 areset = 0;
    @(negedge clk);
    chk("rst_v", 32'(if_a.out_v), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_wgt", 32'(if_a.out_wgt), 32'd0);
    chk("rst_last", 32'(if_a.out_last), 32'd0);
    en = 1;

    // 1: latency and full throughput
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk); chk("lat_e0_v", 32'(m_v), 32'd0);
    @(negedge clk); chk("lat_e1_v", 32'(m_v), 32'd0);
    chk("lat_e1_addr", 32'(m_addr), 32'd1);
    @(negedge clk); chk("lat_e2_v", 32'(m_v), 32'd1);
    wait_frame(0);
    chk("t1_gap", 32'(f_last - f_first), 32'd7);

    // 2: random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) mem_a[i] = W'($urandom);
      pulse_start();
      wait_frame(1);
    end

    // 3: long stall after start
    @(posedge clk); #1 start = 1; out_rdy = 0;
    @(posedge clk); #1 start = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_addr", 32'(m_addr), 32'd2);
    chk("stall_v", 32'(m_v), 32'd1);
    out_rdy = 1;
    wait_frame(0);
    chk("t3_gap", 32'(f_last - f_first), 32'd7);

    // 4: mid-frame start ignored, held start relaunches
    begin
      int s0, k;
      s0 = started;
      pulse_start();
      repeat (2) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
      k = 0;
      while (rem > 2 && k < 100) begin @(posedge clk); #1; k++; end
      start = 1;
      k = 0;
      while (started < s0 + 2 && k < 100) begin
        @(posedge clk); #1; k++;
      end
      start = 0;
      chk("relaunch", 32'(started - s0), 32'd2);
      wait_frame(0);
    end

    // 5: reset after the 5th handshake
    begin
      int k;
      pulse_start();
      k = 0;
      while (rem != 3 && k < 100) begin @(posedge clk); #1; k++; end
      chk("t5_reach", 32'(rem), 32'd3);
      areset = 1;
      @(posedge clk); #1 areset = 0;
      @(negedge clk);
      chk("t5_v", 32'(m_v), 32'd0);
      chk("t5_busy", 32'(m_busy), 32'd0);
      chk("t5_addr", 32'(m_addr), 32'd0);
      chk("t5_done", 32'(m_done), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      pulse_start();
      wait_frame(0);
    end

    // 6: single-word memory, three passes
    sel = 1;
    @(posedge clk); #1;
    pulse_start();
    wait_frame(0);
    chk("t6_gap", 32'(f_last - f_first), 32'd2);
    chk("t6_addr", 32'(m_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
